// File: rtl/synaptic_update_ctrl_pkg.sv
// Shared types and sizing helpers for the synaptic weight read-modify-write controller.
package syn_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MOD  = 2'd1,
      WR   = 2'd2
   } state_e;

   function automatic int nlane_f(input int data_w, input int weight_w);
      return data_w / weight_w;
   endfunction

   function automatic int lane_width_f(input int nlane);
      return (nlane <= 2) ? 1 : $clog2(nlane);
   endfunction

   function automatic int weight_max_f(input int weight_w);
      return (1 << (weight_w - 1)) - 1;
   endfunction

   function automatic int weight_min_f(input int weight_w);
      return -(1 << (weight_w - 1));
   endfunction

endpackage

// File: rtl/synaptic_update_ctrl_if.sv
// Request, response and SRAM-port bundle of the controller; slave is the controller's view.
interface synaptic_update_ctrl_if
   import syn_pkg::*;
#(
   parameter int ADDR_WIDTH   = 8,
   parameter int DATA_WIDTH   = 32,
   parameter int WEIGHT_WIDTH = 8
);
   localparam int LANE_WIDTH = lane_width_f(nlane_f(DATA_WIDTH, WEIGHT_WIDTH));

   logic                    rd_valid;
   logic                    rd_ready;
   logic [ADDR_WIDTH-1:0]   rd_addr;
   logic                    rd_data_valid;
   logic [DATA_WIDTH-1:0]   rd_data;
   logic                    upd_valid;
   logic                    upd_ready;
   logic [ADDR_WIDTH-1:0]   upd_addr;
   logic [LANE_WIDTH-1:0]   upd_lane;
   logic [WEIGHT_WIDTH-1:0] upd_delta;
   logic                    upd_done;
   logic                    upd_sat;
   logic                    sram_cs;
   logic                    sram_we;
   logic [ADDR_WIDTH-1:0]   sram_a;
   logic [DATA_WIDTH-1:0]   sram_d;
   logic [DATA_WIDTH-1:0]   sram_q;

   modport slave (
      input  rd_valid, rd_addr, upd_valid, upd_addr, upd_lane, upd_delta, sram_q,
      output rd_ready, rd_data_valid, rd_data, upd_ready, upd_done, upd_sat,
             sram_cs, sram_we, sram_a, sram_d
   );

   modport master (
      output rd_valid, rd_addr, upd_valid, upd_addr, upd_lane, upd_delta, sram_q,
      input  rd_ready, rd_data_valid, rd_data, upd_ready, upd_done, upd_sat,
             sram_cs, sram_we, sram_a, sram_d
   );

endinterface

// File: rtl/synaptic_update_ctrl_lane_adder.sv
// Single-lane signed weight add; clamps and flags a clip when SYN_UPDATE_SAT_EN is defined, else wraps.
module syn_lane_adder
   import syn_pkg::*;
#(
   parameter int WEIGHT_WIDTH = 8
) (
   input  logic [WEIGHT_WIDTH-1:0] old_w,
   input  logic [WEIGHT_WIDTH-1:0] delta,
   output logic [WEIGHT_WIDTH-1:0] new_w,
   output logic                    sat
);

`ifdef SYN_UPDATE_SAT_EN
   localparam logic signed [WEIGHT_WIDTH:0] W_MAX = (WEIGHT_WIDTH+1)'(weight_max_f(WEIGHT_WIDTH));
   localparam logic signed [WEIGHT_WIDTH:0] W_MIN = (WEIGHT_WIDTH+1)'(weight_min_f(WEIGHT_WIDTH));

   logic signed [WEIGHT_WIDTH:0] sum;

   assign sum = $signed({old_w[WEIGHT_WIDTH-1], old_w}) + $signed({delta[WEIGHT_WIDTH-1], delta});

   always_comb begin
      new_w = sum[WEIGHT_WIDTH-1:0];
      sat   = 1'b0;
      if (sum > W_MAX) begin
         new_w = W_MAX[WEIGHT_WIDTH-1:0];
         sat   = 1'b1;
      end else if (sum < W_MIN) begin
         new_w = W_MIN[WEIGHT_WIDTH-1:0];
         sat   = 1'b1;
      end
   end
`else
   // The extended sum's top bit is discarded by the wrap, so a plain W-bit add is identical.
   assign new_w = old_w + delta;
   assign sat   = 1'b0;
`endif

endmodule

// File: rtl/synaptic_update_ctrl.sv
// Weight SRAM front-end: 1-cycle pipelined reads with priority, 3-cycle lane RMW updates (SYN_UPDATE_SAT_EN clamps).
// Requests are accepted only in IDLE; an update is held off whenever a read is requesting.
module synaptic_update_ctrl
   import syn_pkg::*;
#(
   parameter int ADDR_WIDTH   = 8,
   parameter int DATA_WIDTH   = 32,
   parameter int WEIGHT_WIDTH = 8
) (
   input logic                    CK,
   input logic                    RST_N,
   synaptic_update_ctrl_if.slave  bus
);
   localparam int NLANE      = nlane_f(DATA_WIDTH, WEIGHT_WIDTH);
   localparam int LANE_WIDTH = lane_width_f(NLANE);

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [LANE_WIDTH-1:0]   lane_q, lane_d;
   logic [WEIGHT_WIDTH-1:0] delta_q, delta_d;
   logic [DATA_WIDTH-1:0]   word_q, word_d;
   logic                    sat_q, sat_d;
   logic                    rd_pend_q, rd_pend_d;

   logic                    is_idle, rd_acc, upd_acc;
   logic                    lane_hit, add_sat;
   logic [WEIGHT_WIDTH-1:0] old_lane, new_lane;
   logic [DATA_WIDTH-1:0]   merged;
   logic                    sram_cs, sram_we;
   logic [ADDR_WIDTH-1:0]   sram_a;
   logic [DATA_WIDTH-1:0]   sram_d;

   assign is_idle       = (state_q == IDLE);
   assign bus.rd_ready  = is_idle & RST_N;
   assign bus.upd_ready = is_idle & ~bus.rd_valid & RST_N;
   assign rd_acc        = bus.rd_valid & bus.rd_ready;
   assign upd_acc       = bus.upd_valid & bus.upd_ready;

   // In MOD the SRAM Q carries the fetched word; an out-of-range lane matches nothing.
   always_comb begin
      old_lane = '0;
      lane_hit = 1'b0;
      for (int k = 0; k < NLANE; k++) begin
         if (lane_q == LANE_WIDTH'(k)) begin
            old_lane = bus.sram_q[k*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            lane_hit = 1'b1;
         end
      end
   end

   syn_lane_adder #(.WEIGHT_WIDTH(WEIGHT_WIDTH)) u_adder (
      .old_w (old_lane),
      .delta (delta_q),
      .new_w (new_lane),
      .sat   (add_sat)
   );

   always_comb begin
      merged = bus.sram_q;
      for (int k = 0; k < NLANE; k++) begin
         if (lane_q == LANE_WIDTH'(k)) begin
            merged[k*WEIGHT_WIDTH +: WEIGHT_WIDTH] = new_lane;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      lane_d    = lane_q;
      delta_d   = delta_q;
      word_d    = word_q;
      sat_d     = sat_q;
      rd_pend_d = rd_acc;
      case (state_q)
         IDLE: begin
            if (upd_acc) begin
               state_d = MOD;
               addr_d  = bus.upd_addr;
               lane_d  = bus.upd_lane;
               delta_d = bus.upd_delta;
            end
         end
         MOD: begin
            state_d = WR;
            word_d  = merged;
            sat_d   = add_sat & lane_hit;
         end
         WR:      state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Single port: the fetch shares IDLE with reads (mutually exclusive), write-back owns WR.
   always_comb begin
      sram_cs = 1'b0;
      sram_we = 1'b0;
      sram_a  = '0;
      sram_d  = '0;
      if (rd_acc) begin
         sram_cs = 1'b1;
         sram_a  = bus.rd_addr;
      end else if (upd_acc) begin
         sram_cs = 1'b1;
         sram_a  = bus.upd_addr;
      end else if (state_q == WR) begin
         sram_cs = 1'b1;
         sram_we = 1'b1;
         sram_a  = addr_q;
         sram_d  = word_q;
      end
   end

   assign bus.sram_cs       = sram_cs;
   assign bus.sram_we       = sram_we;
   assign bus.sram_a        = sram_a;
   assign bus.sram_d        = sram_d;
   assign bus.rd_data_valid = rd_pend_q;
   assign bus.rd_data       = rd_pend_q ? bus.sram_q : '0;
   assign bus.upd_done      = (state_q == WR);
   assign bus.upd_sat       = (state_q == WR) & sat_q;

   always_ff @(posedge CK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         lane_q    <= '0;
         delta_q   <= '0;
         word_q    <= '0;
         sat_q     <= 1'b0;
         rd_pend_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         lane_q    <= lane_d;
         delta_q   <= delta_d;
         word_q    <= word_d;
         sat_q     <= sat_d;
         rd_pend_q <= rd_pend_d;
      end
   end

endmodule

// File: tb/tb_synaptic_update_ctrl.sv
// Scoreboard bench: stimulus pushes expectations from a lane-arithmetic reference model, a negedge monitor pops and compares.
module tb_synaptic_update_ctrl;

   logic CK;
   logic RST_N;

   synaptic_update_ctrl_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .WEIGHT_WIDTH(8)) bus ();

   synaptic_update_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .WEIGHT_WIDTH(8)) dut (
      .CK    (CK),
      .RST_N (RST_N),
      .bus   (bus)
   );

   initial CK = 1'b0;
   always #5 CK = ~CK;

   // Behavioural single-port SRAM with registered Q that holds while CS is low.
   logic [31:0] mem [256];
   logic [31:0] q_r;
   always @(posedge CK) begin
      if (bus.sram_cs) begin
         if (bus.sram_we) mem[bus.sram_a] <= bus.sram_d;
         else             q_r <= mem[bus.sram_a];
      end
   end
   assign bus.sram_q = q_r;

   typedef struct { int cyc; logic [31:0] data; } rd_exp_t;
   typedef struct { int cyc; logic [7:0] addr; logic [31:0] word; logic sat; } upd_exp_t;

   rd_exp_t     rdq[$];
   upd_exp_t    updq[$];
   logic [31:0] ref_mem [256];
   int          cyc;
   int          n_cmp;
   int          n_fail;

   always @(posedge CK) cyc <= cyc + 1;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Reference: signed lane add on plain integers, then clamp or wrap.
   function automatic void model_upd(input logic [7:0] a, input int lane, input logic [7:0] dlt,
                                     output logic [31:0] w, output logic sat);
      int o;
      int s;
      logic [7:0] ov;
      w   = ref_mem[a];
      sat = 1'b0;
      if (lane < 4) begin
         ov = w[lane*8 +: 8];
         o  = int'($signed(ov));
         s  = o + int'($signed(dlt));
`ifdef SYN_UPDATE_SAT_EN
         if (s > 127) begin s = 127; sat = 1'b1; end
         else if (s < -128) begin s = -128; sat = 1'b1; end
`endif
         w[lane*8 +: 8] = s[7:0];
      end
      ref_mem[a] = w;
   endfunction

   function automatic void push_rd(input logic [7:0] a);
      rd_exp_t e;
      e.cyc  = cyc + 1;
      e.data = ref_mem[a];
      rdq.push_back(e);
   endfunction

   function automatic void push_upd(input logic [7:0] a, input int lane, input logic [7:0] dlt);
      upd_exp_t e;
      e.cyc  = cyc + 2;
      e.addr = a;
      model_upd(a, lane, dlt, e.word, e.sat);
      updq.push_back(e);
   endfunction

   always @(negedge CK) begin
      rd_exp_t  re;
      upd_exp_t ue;
      if (bus.rd_data_valid) begin
         if (rdq.size() == 0) chk("rd_unexpected", 1, 0);
         else begin
            re = rdq.pop_front();
            chk("rd_data", bus.rd_data, re.data);
            chk("rd_latency", cyc, re.cyc);
         end
      end else if (RST_N) begin
         chk("rd_data_idle_zero", bus.rd_data, 0);
      end
      if (bus.upd_done) begin
         if (updq.size() == 0) chk("upd_unexpected", 1, 0);
         else begin
            ue = updq.pop_front();
            chk("wr_cs_we", {bus.sram_cs, bus.sram_we}, 2'b11);
            chk("wr_addr", bus.sram_a, ue.addr);
            chk("wr_data", bus.sram_d, ue.word);
            chk("upd_sat", bus.upd_sat, ue.sat);
            chk("upd_latency", cyc, ue.cyc);
         end
      end else if (RST_N) begin
         chk("upd_sat_idle_zero", bus.upd_sat, 0);
      end
   end

   task automatic all_zero(input string tag);
      chk({tag, "_rd_ready"}, bus.rd_ready, 0);
      chk({tag, "_upd_ready"}, bus.upd_ready, 0);
      chk({tag, "_rd_data_valid"}, bus.rd_data_valid, 0);
      chk({tag, "_upd_done"}, bus.upd_done, 0);
      chk({tag, "_upd_sat"}, bus.upd_sat, 0);
      chk({tag, "_sram_cs_we"}, {bus.sram_cs, bus.sram_we}, 0);
      chk({tag, "_sram_a"}, bus.sram_a, 0);
      chk({tag, "_sram_d"}, bus.sram_d, 0);
      chk({tag, "_rd_data"}, bus.rd_data, 0);
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic do_read(input logic [7:0] a, output int waited);
      waited = 0;
      bus.rd_valid = 1'b1;
      bus.rd_addr  = a;
      @(negedge CK);
      while (!bus.rd_ready && waited < 50) begin waited++; @(negedge CK); end
      if (!bus.rd_ready) chk("rd_accept_timeout", 0, 1);
      else push_rd(a);
      @(posedge CK); #1;
      bus.rd_valid = 1'b0;
   endtask

   task automatic do_upd(input logic [7:0] a, input int lane, input logic [7:0] dlt, output int waited);
      waited = 0;
      bus.upd_valid = 1'b1;
      bus.upd_addr  = a;
      bus.upd_lane  = 2'(lane);
      bus.upd_delta = dlt;
      @(negedge CK);
      while (!bus.upd_ready && waited < 50) begin waited++; @(negedge CK); end
      if (!bus.upd_ready) chk("upd_accept_timeout", 0, 1);
      else push_upd(a, lane, dlt);
      @(posedge CK); #1;
      bus.upd_valid = 1'b0;
   endtask

   task automatic do_both(input logic [7:0] ra, input logic [7:0] ua, input int lane, input logic [7:0] dlt);
      int w;
      bus.upd_valid = 1'b1;
      bus.upd_addr  = ua;
      bus.upd_lane  = 2'(lane);
      bus.upd_delta = dlt;
      do_read(ra, w);
      chk("both_upd_blocked_by_read", bus.upd_ready, 0);
      do_upd(ua, lane, dlt, w);
      chk("both_upd_next_cycle", w, 0);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge CK);
      #1;
   endtask

   task automatic preload5();
      mem[5]     = 32'h7F1080FE;
      ref_mem[5] = 32'h7F1080FE;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int w;
      logic [31:0] saved;
      n_cmp = 0; n_fail = 0; cyc = 0; q_r = '0;
      RST_N = 1'b0;
      bus.rd_valid = 1'b0; bus.rd_addr = '0;
      bus.upd_valid = 1'b0; bus.upd_addr = '0; bus.upd_lane = '0; bus.upd_delta = '0;
      for (int i = 0; i < 256; i++) begin
         mem[i]     = $urandom;
         ref_mem[i] = mem[i];
      end
      preload5();
      @(negedge CK);
      all_zero("reset");
      @(posedge CK); #1;
      RST_N = 1'b1;
      idle(1);

      // 1: lane 2 += 3, handshake held off during MOD and WR
      do_upd(8'h05, 2, 8'h03, w);
      @(negedge CK); chk("t1_upd_ready_mod", bus.upd_ready, 0);
      @(negedge CK); chk("t1_upd_ready_wr", bus.upd_ready, 0);
      idle(2);

      // 2: lane 3 += 1 at +127
      preload5();
      do_upd(8'h05, 3, 8'h01, w);
      idle(3);

      // 3: lane 1 -= 1 at -128, then lane 0 += 2 at -2
      preload5();
      do_upd(8'h05, 1, 8'hFF, w);
      idle(3);
      preload5();
      do_upd(8'h05, 0, 8'h02, w);
      idle(3);
      do_read(8'h05, w);
      idle(2);

      // 4: read and update together
      preload5();
      do_both(8'h05, 8'h05, 2, 8'h03);
      idle(3);

      // 5: back-to-back reads, then a read held off by an update
      bus.rd_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         do_read(8'(i), w);
         chk("t5_read_no_wait", w, 0);
         bus.rd_valid = 1'b1;
      end
      bus.rd_valid = 1'b0;
      idle(1);
      do_upd(8'h05, 0, 8'h10, w);
      bus.rd_valid = 1'b1; bus.rd_addr = 8'h05;
      @(negedge CK); chk("t5_rd_ready_mod", bus.rd_ready, 0);
      @(negedge CK); chk("t5_rd_ready_wr", bus.rd_ready, 0);
      @(posedge CK); #1;
      do_read(8'h05, w);
      chk("t5_read_after_update_wait", w, 0);
      idle(2);

      // 6: reset during MOD drops the write
      preload5();
      saved = ref_mem[5];
      do_upd(8'h05, 1, 8'h20, w);
      RST_N = 1'b0;
      #1;
      all_zero("t6_rst_in_mod");
      void'(updq.pop_back());
      ref_mem[5] = saved;
      idle(2);
      RST_N = 1'b1;
      do_upd(8'h07, 2, 8'h05, w);
      chk("t6_upd_after_release_wait", w, 0);
      idle(3);
      do_read(8'h05, w);
      idle(2);

      // Randomized mix against the reference model
      for (int n = 0; n < 200; n++) begin
         int op;
         op = $urandom_range(0, 9);
         if (op < 4)      do_read(8'($urandom_range(0, 15)), w);
         else if (op < 8) do_upd(8'($urandom_range(0, 15)), $urandom_range(0, 3), 8'($urandom), w);
         else             do_both(8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
                                  $urandom_range(0, 3), 8'($urandom));
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      idle(6);
      chk("rd_queue_drained", rdq.size(), 0);
      chk("upd_queue_drained", updq.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
